// File: rtl/fb_write_arbiter.sv
// rtl/fb_write_arbiter.sv - round-robin arbiter sharing framebuffer write port B between rasterizer and buffered CPU writes
// Optional feature macro: FB_BOUNDS_CHECK_EN (drop and flag writes with addr >= TOTAL_WORDS)
module fb_write_arbiter #(
   parameter int A_WIDTH     = 16,
   parameter int D_WIDTH     = 3,
   parameter int TOTAL_WORDS = 34240,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic               clk,
   input  logic               n_rst_async,
   input  logic               gpu_valid,
   output logic               gpu_ready,
   input  logic [A_WIDTH-1:0] gpu_addr,
   input  logic [D_WIDTH-1:0] gpu_pixel,
   input  logic               cpu_valid,
   output logic               cpu_ready,
   input  logic [A_WIDTH-1:0] cpu_addr,
   input  logic [D_WIDTH-1:0] cpu_pixel,
   output logic [A_WIDTH-1:0] fb_addr,
   output logic               fb_write_en,
   output logic [D_WIDTH-1:0] fb_pixel,
   output logic               busy,
   output logic               oob_error
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int EW = A_WIDTH + D_WIDTH;
   localparam logic [31:0] TOTAL_W32 = TOTAL_WORDS;

`ifdef FB_BOUNDS_CHECK_EN
   localparam logic BOUNDS_EN = 1'b1;
`else
   localparam logic BOUNDS_EN = 1'b0;
`endif

   typedef enum logic {GRANT_GPU = 1'b0, GRANT_CPU = 1'b1} grant_e;

   logic [EW-1:0]      mem_q [FIFO_DEPTH];
   logic [PW:0]        wr_ptr_q, wr_ptr_d;
   logic [PW:0]        rd_ptr_q, rd_ptr_d;
   logic               full_q, full_d;
   logic               empty_q, empty_d;
   grant_e             last_grant_q;
   logic [A_WIDTH-1:0] fb_addr_q;
   logic [D_WIDTH-1:0] fb_pixel_q;
   logic               fb_write_en_q;
   logic               oob_error_q;

   logic               push, gpu_grant, cpu_grant, issue, drop;
   logic [EW-1:0]      head;
   logic [A_WIDTH-1:0] sel_addr;
   logic [D_WIDTH-1:0] sel_pixel;

   always_comb begin
      cpu_ready = ~full_q;
      gpu_ready = empty_q | (last_grant_q == GRANT_CPU);
      push      = cpu_valid & ~full_q;
      gpu_grant = gpu_valid & gpu_ready;
      // Only entries already in the FIFO (registered empty flag) compete: no same-cycle bypass.
      cpu_grant = ~gpu_grant & ~empty_q;
      issue     = gpu_grant | cpu_grant;

      wr_ptr_d  = wr_ptr_q + {{PW{1'b0}}, push};
      rd_ptr_d  = rd_ptr_q + {{PW{1'b0}}, cpu_grant};
      empty_d   = (wr_ptr_d == rd_ptr_d);
      full_d    = (wr_ptr_d[PW] != rd_ptr_d[PW]) && (wr_ptr_d[PW-1:0] == rd_ptr_d[PW-1:0]);

      head      = mem_q[rd_ptr_q[PW-1:0]];
      sel_addr  = gpu_grant ? gpu_addr  : head[EW-1:D_WIDTH];
      sel_pixel = gpu_grant ? gpu_pixel : head[D_WIDTH-1:0];
      drop      = BOUNDS_EN & (32'(sel_addr) >= TOTAL_W32);
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[PW-1:0]] <= {cpu_addr, cpu_pixel};
      end
   end

   always_ff @(posedge clk or negedge n_rst_async) begin
      if (!n_rst_async) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         full_q        <= 1'b0;
         empty_q       <= 1'b1;
         last_grant_q  <= GRANT_CPU;
         fb_addr_q     <= '0;
         fb_pixel_q    <= '0;
         fb_write_en_q <= 1'b0;
         oob_error_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         if (gpu_grant) begin
            last_grant_q <= GRANT_GPU;
         end else if (cpu_grant) begin
            last_grant_q <= GRANT_CPU;
         end
         // A dropped out-of-range write still consumes its grant but leaves the port idle.
         fb_write_en_q <= issue & ~drop;
         oob_error_q   <= issue & drop;
         if (issue && !drop) begin
            fb_addr_q  <= sel_addr;
            fb_pixel_q <= sel_pixel;
         end
      end
   end

   assign fb_addr     = fb_addr_q;
   assign fb_pixel    = fb_pixel_q;
   assign fb_write_en = fb_write_en_q;
   assign oob_error   = oob_error_q;
   assign busy        = ~empty_q | fb_write_en_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb/tb_fb_write_arbiter.sv - randomized self-checking bench for fb_write_arbiter against a queue-based model
module tb_fb_write_arbiter;

   localparam int TW    = 34240;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        n_rst_async = 1'b0;
   logic        gpu_valid = 1'b0, cpu_valid = 1'b0;
   logic [15:0] gpu_addr = '0, cpu_addr = '0;
   logic [2:0]  gpu_pixel = '0, cpu_pixel = '0;
   logic        gpu_ready, cpu_ready, fb_write_en, busy, oob_error;
   logic [15:0] fb_addr;
   logic [2:0]  fb_pixel;

   fb_write_arbiter dut (
      .clk(clk), .n_rst_async(n_rst_async),
      .gpu_valid(gpu_valid), .gpu_ready(gpu_ready), .gpu_addr(gpu_addr), .gpu_pixel(gpu_pixel),
      .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_addr(cpu_addr), .cpu_pixel(cpu_pixel),
      .fb_addr(fb_addr), .fb_write_en(fb_write_en), .fb_pixel(fb_pixel),
      .busy(busy), .oob_error(oob_error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [2:0]  p;
   } wr_t;

   wr_t         cpu_q[$];
   bit          m_last_gpu;
   bit          m_en, m_oob;
   logic [15:0] m_addr;
   logic [2:0]  m_pix;
   int          n_checks = 0, n_errors = 0;
   int          obs_gpu = 0, obs_cpu = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit is_oob(input logic [15:0] a);
`ifdef FB_BOUNDS_CHECK_EN
      return int'(a) >= TW;
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_reset();
      cpu_q.delete();
      m_last_gpu = 1'b0;
      m_en = 1'b0; m_oob = 1'b0; m_addr = '0; m_pix = '0;
   endtask

   // Called just after a falling edge: compare outputs, drive inputs, advance the model one cycle.
   task automatic step(input bit gv, input logic [15:0] ga, input logic [2:0] gp,
                       input bit cv, input logic [15:0] ca, input logic [2:0] cp);
      bit  exp_cr, exp_gr, gg, cg;
      wr_t w;
      exp_cr = cpu_q.size() < DEPTH;
      exp_gr = (cpu_q.size() == 0) || !m_last_gpu;
      check("fb_write_en", 32'(fb_write_en), 32'(m_en));
      check("fb_addr", 32'(fb_addr), 32'(m_addr));
      check("fb_pixel", 32'(fb_pixel), 32'(m_pix));
      check("oob_error", 32'(oob_error), 32'(m_oob));
      check("busy", 32'(busy), 32'((cpu_q.size() > 0) || m_en));
      check("cpu_ready", 32'(cpu_ready), 32'(exp_cr));
      check("gpu_ready", 32'(gpu_ready), 32'(exp_gr));
      if (fb_write_en) begin
         if (fb_addr[15:12] == 4'h1) obs_gpu++;
         if (fb_addr[15:12] == 4'h2) obs_cpu++;
      end

      gpu_valid = gv; gpu_addr = ga; gpu_pixel = gp;
      cpu_valid = cv; cpu_addr = ca; cpu_pixel = cp;

      gg = gv && exp_gr;
      cg = !gg && (cpu_q.size() > 0);
      m_en = 1'b0; m_oob = 1'b0;
      if (gg || cg) begin
         if (gg) begin
            w.a = ga; w.p = gp;
            m_last_gpu = 1'b1;
         end else begin
            w = cpu_q.pop_front();
            m_last_gpu = 1'b0;
         end
         if (is_oob(w.a)) m_oob = 1'b1;
         else begin
            m_en = 1'b1; m_addr = w.a; m_pix = w.p;
         end
      end
      if (cv && exp_cr) begin
         w.a = ca; w.p = cp;
         cpu_q.push_back(w);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, '0);
   endtask

   function automatic logic [15:0] rand_addr();
      int unsigned r;
      r = $urandom_range(0, 7);
      case (r)
         0: return 16'(TW - 1);
         1: return 16'(TW);
         2: return 16'hFFFF;
         default: return 16'($urandom);
      endcase
   endfunction

   initial begin
      int pushed;
      int guard;
      model_reset();

      // Reset held with both requesters asserting
      gpu_valid = 1; cpu_valid = 1; gpu_addr = 16'h1234; cpu_addr = 16'h4321;
      repeat (3) @(negedge clk);
      check("rst_fb_write_en", 32'(fb_write_en), 32'd0);
      check("rst_fb_addr", 32'(fb_addr), 32'd0);
      check("rst_cpu_ready", 32'(cpu_ready), 32'd1);
      check("rst_gpu_ready", 32'(gpu_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      gpu_valid = 0; cpu_valid = 0;
      n_rst_async = 1'b1;
      @(negedge clk);

      // GPU single write
      step(1, 16'h0010, 3'b101, 0, '0, '0);
      check("gpu_lat_en", 32'(fb_write_en), 32'd1);
      check("gpu_lat_addr", 32'(fb_addr), 32'h0010);
      check("gpu_lat_pix", 32'(fb_pixel), 32'b101);
      idle(2);

      // Five back-to-back CPU pushes under constant GPU traffic
      pushed = 0; guard = 0;
      while (pushed < 5 && guard < 40) begin
         if (cpu_q.size() < DEPTH) pushed++;
         step(1, 16'h1000 + 16'(guard), 3'(guard), 1, 16'h2000 + 16'(pushed), 3'(pushed));
         guard++;
      end
      check("cpu_fill_pushes", 32'(pushed), 32'd5);
      idle(8);

      // Contention: 8 cycles of both valid
      obs_gpu = 0; obs_cpu = 0;
      for (int i = 0; i < 8; i++)
         step(1, 16'h1100 + 16'(i), 3'(i), 1, 16'h2100 + 16'(i), 3'(7 - i));
      step(0, '0, '0, 0, '0, '0);
      check("contention_gpu_writes", 32'(obs_gpu), 32'd4);
      check("contention_cpu_writes", 32'(obs_cpu), 32'd4);
      idle(8);

      // Reset mid-operation with CPU entries queued
      guard = 0;
      while (cpu_q.size() < 3 && guard < 20) begin
         step(1, 16'h1200, 3'd1, 1, 16'h2200 + 16'(guard), 3'd2);
         guard++;
      end
      check("midrst_queued", 32'(cpu_q.size() >= 3), 32'd1);
      n_rst_async = 1'b0;
      gpu_valid = 0; cpu_valid = 0;
      #1;
      check("midrst_en", 32'(fb_write_en), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_cpu_ready", 32'(cpu_ready), 32'd1);
      @(negedge clk);
      n_rst_async = 1'b1;
      model_reset();
      idle(4);

`ifdef FB_BOUNDS_CHECK_EN
      step(0, '0, '0, 1, 16'(TW), 3'b111);
      step(0, '0, '0, 0, '0, '0);
      check("oob_pulse", 32'(oob_error), 32'd1);
      check("oob_no_write", 32'(fb_write_en), 32'd0);
      step(0, '0, '0, 1, 16'(TW - 1), 3'b011);
      check("oob_cleared", 32'(oob_error), 32'd0);
      step(0, '0, '0, 0, '0, '0);
      check("last_word_en", 32'(fb_write_en), 32'd1);
      check("last_word_addr", 32'(fb_addr), 32'(TW - 1));
      idle(2);
`endif

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 3) != 0, rand_addr(), 3'($urandom),
              $urandom_range(0, 2) != 0, rand_addr(), 3'($urandom));
      end
      idle(10);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
